// File: rtl/usb_tx_arbiter_pkg.sv
// usb_tx_arbiter_pkg: shared types for the USB response-path scheduler.
//   TxArbState - scheduler FSM encoding (3 bits)
//   Pid        - 4-bit USB packet identifier carried to the encoder
package usb_tx_arbiter_pkg;

  localparam int unsigned PID_W = 4;

  typedef logic [PID_W-1:0] Pid;

  typedef enum logic [2:0] {
    TX_IDLE  = 3'd0,
    TX_GAP   = 3'd1,
    TX_ARB   = 3'd2,
    TX_START = 3'd3,
    TX_BUSY  = 3'd4
  } TxArbState;

endpackage

// File: rtl/usb_tx_arbiter_if.sv
// usb_tx_arbiter_if: requester and encoder handshake bundle.
//   req_valid/req_pid/req_is_data : requester -> arbiter transmit requests
//   grant/done                    : arbiter -> requester ownership and completion
//   enc_start/enc_pid/enc_is_data : arbiter -> encoder packet launch
//   enc_done                      : encoder -> arbiter EOP driven
// master = arbiter side, slave = requester/encoder side.
interface usb_tx_arbiter_if #(
  parameter int unsigned NUM_EP = 4
);
  import usb_tx_arbiter_pkg::*;

  logic [NUM_EP-1:0]       req_valid;
  logic [PID_W*NUM_EP-1:0] req_pid;
  logic [NUM_EP-1:0]       req_is_data;
  logic [NUM_EP-1:0]       grant;
  logic [NUM_EP-1:0]       done;
  logic                    enc_start;
  Pid                      enc_pid;
  logic                    enc_is_data;
  logic                    enc_done;

  modport master (
    input  req_valid, req_pid, req_is_data, enc_done,
    output grant, done, enc_start, enc_pid, enc_is_data
  );

  modport slave (
    output req_valid, req_pid, req_is_data, enc_done,
    input  grant, done, enc_start, enc_pid, enc_is_data
  );

endinterface

// File: rtl/usb_tx_arbiter_rr_arbiter.sv
// rr_arbiter: combinational arbiter. Searches req upward from ptr (wrapping)
// and returns the first set bit as a one-hot grant plus its index.
//   req   : request vector
//   ptr   : search start position (tie to 0 for fixed priority)
//   gnt_c : one-hot winner, 0 when no request
//   idx_c : winner index, 0 when no request
module rr_arbiter #(
  parameter int unsigned N = 4,
  localparam int unsigned IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt_c,
  output logic [IW-1:0] idx_c
);

  int unsigned pos;
  logic        found;

  // First requester at or after ptr wins.
  always_comb begin
    gnt_c = '0;
    idx_c = '0;
    found = 1'b0;
    pos   = 0;
    for (int unsigned i = 0; i < N; i++) begin
      pos = (32'(ptr) + i) % N;
      if (!found && req[IW'(pos)]) begin
        gnt_c[IW'(pos)] = 1'b1;
        idx_c           = IW'(pos);
        found           = 1'b1;
      end
    end
  end

endmodule

// File: rtl/usb_tx_arbiter.sv
// usb_tx_arbiter: after each received packet, waits the inter-packet gap,
// grants the packet encoder to one requester and sequences start/done; if
// nobody requests within the response window, pulses resp_timeout.
//   clk48, reset (async, active low), bus_reset (sync abort), rx_eop
//   resp_timeout : one-cycle pulse on an unanswered response window
//   bus          : usb_tx_arbiter_if.master (requesters + encoder)
// Build option: TX_ARB_ROUND_ROBIN_EN selects round-robin arbitration;
// otherwise fixed priority, lowest index wins.
module usb_tx_arbiter
  import usb_tx_arbiter_pkg::*;
#(
  parameter int unsigned NUM_EP       = 4,
  parameter int unsigned MIN_GAP      = 8,
  parameter int unsigned RESP_TIMEOUT = 26
) (
  input  logic            clk48,
  input  logic            reset,
  input  logic            bus_reset,
  input  logic            rx_eop,
  output logic            resp_timeout,
  usb_tx_arbiter_if.master bus
);

  localparam int unsigned CNT_W = $clog2(RESP_TIMEOUT + 1);
  localparam int unsigned IDX_W = $clog2(NUM_EP);

  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(MIN_GAP - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(RESP_TIMEOUT - 1);

  localparam logic [2:0] ST_IDLE  = 3'(TX_IDLE);
  localparam logic [2:0] ST_GAP   = 3'(TX_GAP);
  localparam logic [2:0] ST_ARB   = 3'(TX_ARB);
  localparam logic [2:0] ST_START = 3'(TX_START);
  localparam logic [2:0] ST_BUSY  = 3'(TX_BUSY);

  logic [2:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
  logic [NUM_EP-1:0] grant_q, grant_d;
  logic [NUM_EP-1:0] done_q, done_d;
  logic              resp_timeout_q, resp_timeout_d;
  logic              enc_start_q, enc_start_d;
  Pid                enc_pid_q, enc_pid_d;
  logic              enc_is_data_q, enc_is_data_d;
  logic [IDX_W-1:0]  winner_q, winner_d;

  logic [NUM_EP-1:0] win_gnt_c;
  logic [IDX_W-1:0]  win_idx_c;
  logic [IDX_W-1:0]  arb_ptr;
  Pid                req_pid_arr [NUM_EP];

  rr_arbiter #(.N(NUM_EP)) u_arb (
    .req   (bus.req_valid),
    .ptr   (arb_ptr),
    .gnt_c (win_gnt_c),
    .idx_c (win_idx_c)
  );

  // Unpack per-requester PIDs.
  always_comb begin
    for (int unsigned i = 0; i < NUM_EP; i++) begin
      req_pid_arr[i] = bus.req_pid[PID_W*i +: PID_W];
    end
  end

`ifdef TX_ARB_ROUND_ROBIN_EN
  logic [IDX_W-1:0] ptr_q, ptr_d;

  // Pointer moves past the most recent winner.
  always_comb begin
    ptr_d = ptr_q;
    if (bus_reset) begin
      ptr_d = '0;
    end else if (state_q == ST_ARB && |bus.req_valid) begin
      ptr_d = (win_idx_c == IDX_W'(NUM_EP - 1)) ? '0 : win_idx_c + 1'b1;
    end
  end

  always_ff @(posedge clk48 or negedge reset) begin
    if (!reset) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

  assign arb_ptr = ptr_q;
`else
  assign arb_ptr = '0;
`endif

  // Counter holds the number of cycles elapsed since rx_eop; saturates.
  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

  // Next-state and registered-output logic.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    grant_d        = grant_q;
    done_d         = '0;
    resp_timeout_d = 1'b0;
    enc_start_d    = 1'b0;
    enc_pid_d      = enc_pid_q;
    enc_is_data_d  = enc_is_data_q;
    winner_d       = winner_q;
    if (bus_reset) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      grant_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          cnt_d = CNT_W'(rx_eop);
          if (rx_eop) state_d = ST_GAP;
        end
        ST_GAP: begin
          cnt_d = cnt_inc;
          if (cnt_inc >= GAP_LAST) state_d = ST_ARB;
        end
        ST_ARB: begin
          cnt_d = cnt_inc;
          // A request beats a timeout that falls in the same cycle.
          if (|bus.req_valid) begin
            grant_d       = win_gnt_c;
            winner_d      = win_idx_c;
            enc_pid_d     = req_pid_arr[win_idx_c];
            enc_is_data_d = bus.req_is_data[win_idx_c];
            state_d       = ST_START;
          end else if (cnt_q >= TO_LAST) begin
            resp_timeout_d = 1'b1;
            state_d        = ST_IDLE;
          end
        end
        ST_START: begin
          enc_start_d = 1'b1;
          state_d     = ST_BUSY;
        end
        ST_BUSY: begin
          if (bus.enc_done) begin
            done_d[winner_q] = 1'b1;
            grant_d          = '0;
            state_d          = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk48 or negedge reset) begin
    if (!reset) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      grant_q        <= '0;
      done_q         <= '0;
      resp_timeout_q <= 1'b0;
      enc_start_q    <= 1'b0;
      enc_pid_q      <= '0;
      enc_is_data_q  <= 1'b0;
      winner_q       <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      grant_q        <= grant_d;
      done_q         <= done_d;
      resp_timeout_q <= resp_timeout_d;
      enc_start_q    <= enc_start_d;
      enc_pid_q      <= enc_pid_d;
      enc_is_data_q  <= enc_is_data_d;
      winner_q       <= winner_d;
    end
  end

  assign bus.grant       = grant_q;
  assign bus.done        = done_q;
  assign bus.enc_start   = enc_start_q;
  assign bus.enc_pid     = enc_pid_q;
  assign bus.enc_is_data = enc_is_data_q;
  assign resp_timeout    = resp_timeout_q;

endmodule

// File: tb/tb_usb_tx_arbiter.sv
// tb_usb_tx_arbiter: directed bench for usb_tx_arbiter. Cycle 0 is the cycle
// in which rx_eop is driven; outputs are sampled 1 time unit after each edge.
module tb_usb_tx_arbiter;

  localparam int unsigned NUM_EP       = 4;
  localparam int unsigned MIN_GAP      = 8;
  localparam int unsigned RESP_TIMEOUT = 26;

  localparam logic [3:0] PID_ACK   = 4'b0010;
  localparam logic [3:0] PID_NAK   = 4'b1010;
  localparam logic [3:0] PID_DATA0 = 4'b0011;
  localparam logic [3:0] PID_DATA1 = 4'b1011;

  logic clk48     = 1'b0;
  logic reset     = 1'b0;
  logic bus_reset = 1'b0;
  logic rx_eop    = 1'b0;
  logic resp_timeout;

  int cyc      = 0;
  int n_assert = 0;
  int n_fail   = 0;

  usb_tx_arbiter_if #(.NUM_EP(NUM_EP)) bus ();

  usb_tx_arbiter #(
    .NUM_EP       (NUM_EP),
    .MIN_GAP      (MIN_GAP),
    .RESP_TIMEOUT (RESP_TIMEOUT)
  ) dut (
    .clk48        (clk48),
    .reset        (reset),
    .bus_reset    (bus_reset),
    .rx_eop       (rx_eop),
    .resp_timeout (resp_timeout),
    .bus          (bus)
  );

  always #5 clk48 = ~clk48;

  task automatic tick();
    @(posedge clk48);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  task automatic set_req(input logic [3:0] v, input logic [15:0] pids, input logic [3:0] dat);
    bus.req_valid   = v;
    bus.req_pid     = pids;
    bus.req_is_data = dat;
  endtask

  // One full window with a granted request and enc_done in cycle 10.
  task automatic run_window(input string tag, input logic [3:0] eg,
                            input logic [3:0] ep, input logic ed);
    rx_eop = 1'b1;
    cyc    = 0;
    tick();
    rx_eop = 1'b0;
    while (cyc < 8) tick();
    chk({tag, "_grant"}, bus.grant, eg);
    chk({tag, "_pid"}, bus.enc_pid, ep);
    chk({tag, "_is_data"}, bus.enc_is_data, ed);
    tick();
    chk({tag, "_start"}, bus.enc_start, 1);
    tick();
    chk({tag, "_start_pulse"}, bus.enc_start, 0);
    bus.enc_done = 1'b1;
    tick();
    bus.enc_done = 1'b0;
    chk({tag, "_done"}, bus.done, eg);
    chk({tag, "_grant_clr"}, bus.grant, 0);
    tick();
    chk({tag, "_done_pulse"}, bus.done, 0);
  endtask

  initial begin
    set_req(4'b0000, 16'h0000, 4'b0000);
    bus.enc_done = 1'b0;

    // Reset values
    #3;
    chk("rst_grant", bus.grant, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_timeout", resp_timeout, 0);
    chk("rst_enc_start", bus.enc_start, 0);
    chk("rst_enc_pid", bus.enc_pid, 0);
    chk("rst_enc_is_data", bus.enc_is_data, 0);
    tick();
    reset = 1'b1;
    tick();
    tick();

    // Single early request on requester 1, extra rx_eop during GAP
    set_req(4'b0010, {4'h0, 4'h0, PID_ACK, 4'h0}, 4'b0000);
    cyc = -5;
    while (cyc < 0) begin
      chk("idle_no_grant", bus.grant, 0);
      chk("idle_no_start", bus.enc_start, 0);
      tick();
    end
    rx_eop = 1'b1;
    tick();
    rx_eop = 1'b0;
    while (cyc < 8) begin
      chk("gap_no_grant", bus.grant, 0);
      chk("gap_no_start", bus.enc_start, 0);
      rx_eop = (cyc == 4);
      tick();
    end
    chk("t1_grant", bus.grant, 4'b0010);
    chk("t1_pid", bus.enc_pid, PID_ACK);
    chk("t1_is_data", bus.enc_is_data, 0);
    chk("t1_start_lo", bus.enc_start, 0);
    tick();
    chk("t1_start", bus.enc_start, 1);
    chk("t1_grant9", bus.grant, 4'b0010);
    tick();
    chk("t1_start_pulse", bus.enc_start, 0);
    while (cyc < 20) begin
      chk("t1_grant_hold", bus.grant, 4'b0010);
      chk("t1_no_done", bus.done, 0);
      tick();
    end
    bus.enc_done = 1'b1;
    tick();
    bus.enc_done = 1'b0;
    chk("t1_done", bus.done, 4'b0010);
    chk("t1_grant_clr", bus.grant, 0);
    tick();
    chk("t1_done_pulse", bus.done, 0);
    set_req(4'b0000, 16'h0000, 4'b0000);
    tick();

    // No request: timeout at cycle 26
    rx_eop = 1'b1;
    cyc    = 0;
    tick();
    rx_eop = 1'b0;
    while (cyc < 26) begin
      chk("t2_no_timeout", resp_timeout, 0);
      chk("t2_no_grant", bus.grant, 0);
      tick();
    end
    chk("t2_timeout", resp_timeout, 1);
    tick();
    chk("t2_timeout_pulse", resp_timeout, 0);
    tick();

    // Request appearing in the timeout cycle wins
    rx_eop = 1'b1;
    cyc    = 0;
    tick();
    rx_eop = 1'b0;
    while (cyc < 25) tick();
    set_req(4'b1000, {PID_DATA1, 4'h0, 4'h0, 4'h0}, 4'b1000);
    tick();
    chk("t3_no_timeout", resp_timeout, 0);
    chk("t3_grant", bus.grant, 4'b1000);
    chk("t3_pid", bus.enc_pid, PID_DATA1);
    chk("t3_is_data", bus.enc_is_data, 1);
    tick();
    chk("t3_start", bus.enc_start, 1);
    bus.enc_done = 1'b1;
    tick();
    bus.enc_done = 1'b0;
    chk("t3_done", bus.done, 4'b1000);
    chk("t3_grant_clr", bus.grant, 0);
    set_req(4'b0000, 16'h0000, 4'b0000);
    tick();

    // Abort during BUSY, with a simultaneous enc_done
    set_req(4'b0010, {4'h0, 4'h0, PID_ACK, 4'h0}, 4'b0000);
    rx_eop = 1'b1;
    cyc    = 0;
    tick();
    rx_eop = 1'b0;
    while (cyc < 12) tick();
    chk("t4_grant_busy", bus.grant, 4'b0010);
    bus_reset    = 1'b1;
    bus.enc_done = 1'b1;
    tick();
    bus_reset    = 1'b0;
    bus.enc_done = 1'b0;
    chk("t4_grant_abort", bus.grant, 0);
    chk("t4_no_done", bus.done, 0);
    set_req(4'b0000, 16'h0000, 4'b0000);
    tick();
    bus.enc_done = 1'b1;
    tick();
    bus.enc_done = 1'b0;
    chk("t4_late_done_ignored", bus.done, 0);
    chk("t4_grant_idle", bus.grant, 0);
    chk("t4_no_start", bus.enc_start, 0);
    tick();

    // Requesters 0 and 2 always requesting, three windows
    set_req(4'b0101, {4'h0, PID_DATA0, 4'h0, PID_NAK}, 4'b0100);
`ifdef TX_ARB_ROUND_ROBIN_EN
    run_window("rr_w1", 4'b0001, PID_NAK, 1'b0);
    run_window("rr_w2", 4'b0100, PID_DATA0, 1'b1);
    run_window("rr_w3", 4'b0001, PID_NAK, 1'b0);
`else
    run_window("fp_w1", 4'b0001, PID_NAK, 1'b0);
    run_window("fp_w2", 4'b0001, PID_NAK, 1'b0);
    run_window("fp_w3", 4'b0001, PID_NAK, 1'b0);
`endif
    set_req(4'b0000, 16'h0000, 4'b0000);
    tick();

    // Async reset mid-GAP, then a normal window
    set_req(4'b0001, {4'h0, 4'h0, 4'h0, PID_ACK}, 4'b0000);
    rx_eop = 1'b1;
    cyc    = 0;
    tick();
    rx_eop = 1'b0;
    while (cyc < 4) tick();
    chk("t6_pid_before_reset", bus.enc_pid, PID_NAK);
    reset = 1'b0;
    #1;
    chk("t6_rst_grant", bus.grant, 0);
    chk("t6_rst_done", bus.done, 0);
    chk("t6_rst_start", bus.enc_start, 0);
    chk("t6_rst_pid", bus.enc_pid, 0);
    chk("t6_rst_is_data", bus.enc_is_data, 0);
    chk("t6_rst_timeout", resp_timeout, 0);
    tick();
    tick();
    reset = 1'b1;
    tick();
    run_window("t6_after", 4'b0001, PID_ACK, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
